// File: rtl/pp_acc_pkg.sv
// Shared constants, row type and FSM state encoding for the shift-add
// partial-product accumulator.
package pp_acc_pkg;

    localparam int PP_WIDTH   = 16;
    localparam int PP_COUNT   = 9;
    localparam int PROD_WIDTH = PP_WIDTH + PP_COUNT;

    typedef logic [PP_WIDTH-1:0] pp_row_t;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } pp_acc_state_e;

endpackage

// File: rtl/pp_lsb_find.sv
// Lowest-set-bit priority encoder: one-hot of the lowest set bit of vec and
// its index (both zero when vec is zero).
module pp_lsb_find #(
    parameter int N     = 9,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     vec,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx
);

    assign onehot = vec & (~vec + N'(1));

    always_comb begin
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/pp_accumulator.sv
// Sequential shift-add reduction of PP_COUNT partial-product rows into one
// product. Optional build macro: PP_ACC_SKIP_ZERO_EN (skip all-zero rows).
module pp_accumulator
    import pp_acc_pkg::*;
#(
    parameter int PP_WIDTH = pp_acc_pkg::PP_WIDTH,
    parameter int PP_COUNT = pp_acc_pkg::PP_COUNT
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PP_WIDTH-1:0]          pp_rows [PP_COUNT],
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [PP_WIDTH+PP_COUNT-1:0] product,
    output logic                         busy,
    output pp_acc_state_e                dbg_state
);

    localparam int SUM_W = PP_WIDTH + PP_COUNT;
    localparam int IDX_W = (PP_COUNT > 1) ? $clog2(PP_COUNT) : 1;

    // Handshakes: a transfer happens on a rising edge where valid && ready are
    // both high; valid never drops and data never changes until that edge.
    pp_acc_state_e        state, state_next;
    logic [PP_WIDTH-1:0]  rows [PP_COUNT];
    logic [SUM_W-1:0]     acc;
    logic [SUM_W-1:0]     addend;
    logic [IDX_W-1:0]     row_sel;
    logic                 last_row;
    logic                 accept;

    assign accept = in_valid && (state == IDLE);

`ifdef PP_ACC_SKIP_ZERO_EN
    logic [PP_COUNT-1:0] mask, in_mask, sel_onehot, mask_next;

    always_comb begin
        in_mask = '0;
        for (int i = 0; i < PP_COUNT; i++) begin
            in_mask[i] = |pp_rows[i];
        end
    end

    pp_lsb_find #(.N(PP_COUNT), .IDX_W(IDX_W)) u_lsb_find (
        .vec    (mask),
        .onehot (sel_onehot),
        .idx    (row_sel)
    );

    // An all-zero set still spends one ACCUM cycle adding row 0 (which is zero).
    assign mask_next = mask & ~sel_onehot;
    assign last_row  = (mask_next == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            mask <= '0;
        end else if (accept) begin
            mask <= in_mask;
        end else if (state == ACCUM) begin
            mask <= mask_next;
        end
    end
`else
    logic [IDX_W-1:0] idx;

    assign row_sel  = idx;
    assign last_row = (idx == IDX_W'(PP_COUNT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
        end else if (accept) begin
            idx <= '0;
        end else if (state == ACCUM) begin
            idx <= idx + IDX_W'(1);
        end
    end
`endif

    assign addend = SUM_W'(rows[row_sel]) << row_sel;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid) state_next = ACCUM;
            ACCUM:   if (last_row) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            rows <= pp_rows;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (accept) begin
            acc <= '0;
        end else if (state == ACCUM) begin
            acc <= acc + addend;
        end
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign product   = acc;
    assign dbg_state = state;

endmodule
